// File: rtl/game_state_ctrl.sv
// Pong game sequencer: menu, max-score setting, serve/play, point hold and game end.
// All state lives in clk_pix flops; outputs decode only from registered state.
module game_state_ctrl #(
    parameter int SCORE_W     = 5,
    parameter int MAX_MIN     = 1,
    parameter int MAX_MAX     = 15,
    parameter int MAX_DEF     = 5,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               clk_pix,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_launch,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               left_hit,
    input  logic               right_hit,
    output logic [2:0]         state,
    output logic               run,
    output logic               ball_reset,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [SCORE_W-1:0] max_score,
    output logic [1:0]         winner
);

    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_SET       = 3'd1,
        S_START     = 3'd2,
        S_PLAY      = 3'd3,
        S_END_POINT = 3'd4,
        S_END_GAME  = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_p1_q, score_p1_d;
    logic [SCORE_W-1:0] score_p2_q, score_p2_d;
    logic [SCORE_W-1:0] max_score_q, max_score_d;
    logic               serve_side_q, serve_side_d;
    logic [1:0]         winner_q, winner_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic               prev_launch_q, prev_up_q, prev_down_q;
    logic               prev_left_q, prev_right_q;

    logic rise_launch, rise_up, rise_down, rise_left, rise_right;

    always_comb begin
        rise_launch = btn_launch & ~prev_launch_q;
        rise_up     = btn_up     & ~prev_up_q;
        rise_down   = btn_down   & ~prev_down_q;
        rise_left   = left_hit   & ~prev_left_q;
        rise_right  = right_hit  & ~prev_right_q;
    end

    always_comb begin
        state_d      = state_q;
        score_p1_d   = score_p1_q;
        score_p2_d   = score_p2_q;
        max_score_d  = max_score_q;
        serve_side_d = serve_side_q;
        winner_d     = winner_q;
        hold_d       = hold_q;

        case (state_q)
            S_MENU: begin
                if (rise_launch) state_d = S_SET;
            end
            S_SET: begin
                if (rise_launch) begin
                    state_d    = S_START;
                    score_p1_d = '0;
                    score_p2_d = '0;
                end else if (rise_up && !rise_down) begin
                    if (max_score_q < SCORE_W'(MAX_MAX))
                        max_score_d = max_score_q + SCORE_W'(1);
                end else if (rise_down && !rise_up) begin
                    if (max_score_q > SCORE_W'(MAX_MIN))
                        max_score_d = max_score_q - SCORE_W'(1);
                end
            end
            S_START: begin
                if (rise_launch) state_d = S_PLAY;
            end
            S_PLAY: begin
                // A simultaneous double hit ends the point without awarding it.
                if (rise_left || rise_right) begin
                    state_d = S_END_POINT;
                    hold_d  = '0;
                    if (rise_right && !rise_left) begin
                        score_p1_d   = score_p1_q + SCORE_W'(1);
                        serve_side_d = 1'b1;
                    end else if (rise_left && !rise_right) begin
                        score_p2_d   = score_p2_q + SCORE_W'(1);
                        serve_side_d = 1'b0;
                    end
                end
            end
            S_END_POINT: begin
                if (frame_tick) begin
                    if (hold_q == CNT_W'(HOLD_FRAMES - 1)) begin
                        hold_d = '0;
                        if (score_p1_q >= max_score_q) begin
                            winner_d = 2'd1;
                            state_d  = S_END_GAME;
                        end else if (score_p2_q >= max_score_q) begin
                            winner_d = 2'd2;
                            state_d  = S_END_GAME;
                        end else begin
                            state_d = S_START;
                        end
                    end else begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
            end
            S_END_GAME: begin
                if (rise_launch) begin
                    state_d  = S_MENU;
                    winner_d = 2'd0;
                end
            end
            default: state_d = S_MENU;
        endcase
    end

    always_ff @(posedge clk_pix) begin
        if (reset) begin
            state_q       <= S_MENU;
            score_p1_q    <= '0;
            score_p2_q    <= '0;
            max_score_q   <= SCORE_W'(MAX_DEF);
            serve_side_q  <= 1'b0;
            winner_q      <= 2'd0;
            hold_q        <= '0;
            // Buttons held through reset must not register as a press.
            prev_launch_q <= 1'b1;
            prev_up_q     <= 1'b1;
            prev_down_q   <= 1'b1;
            prev_left_q   <= 1'b0;
            prev_right_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_p1_q    <= score_p1_d;
            score_p2_q    <= score_p2_d;
            max_score_q   <= max_score_d;
            serve_side_q  <= serve_side_d;
            winner_q      <= winner_d;
            hold_q        <= hold_d;
            prev_launch_q <= btn_launch;
            prev_up_q     <= btn_up;
            prev_down_q   <= btn_down;
            prev_left_q   <= left_hit;
            prev_right_q  <= right_hit;
        end
    end

    assign state      = state_q;
    assign run        = (state_q == S_PLAY);
    assign ball_reset = (state_q == S_START);
    assign serve_side = serve_side_q;
    assign score_p1   = score_p1_q;
    assign score_p2   = score_p2_q;
    assign max_score  = max_score_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: menu/set/serve/play/hold/end flow with
// hand-computed expectations, including reset mid-hold and held-button reset.
module tb_game_state_ctrl;

    logic       clk_pix = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_launch = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       left_hit = 1'b0;
    logic       right_hit = 1'b0;
    logic [2:0] state;
    logic       run;
    logic       ball_reset;
    logic       serve_side;
    logic [4:0] score_p1;
    logic [4:0] score_p2;
    logic [4:0] max_score;
    logic [1:0] winner;

    int errors = 0;
    int checks = 0;

    localparam int MENU = 0, SET = 1, START = 2, PLAY = 3, END_POINT = 4, END_GAME = 5;

    game_state_ctrl dut (
        .clk_pix    (clk_pix),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_launch (btn_launch),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .left_hit   (left_hit),
        .right_hit  (right_hit),
        .state      (state),
        .run        (run),
        .ball_reset (ball_reset),
        .serve_side (serve_side),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .max_score  (max_score),
        .winner     (winner)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("check %s: %0d ok", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
    endtask

    // 0 launch, 1 up, 2 down, 3 left hit, 4 right hit, 5 both hits, 6 up+down
    task automatic press(input int which);
        btn_launch = (which == 0);
        btn_up     = (which == 1) || (which == 6);
        btn_down   = (which == 2) || (which == 6);
        left_hit   = (which == 3) || (which == 5);
        right_hit  = (which == 4) || (which == 5);
        step();
        btn_launch = 1'b0;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        left_hit   = 1'b0;
        right_hit  = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    task automatic check_scores(input string tag, input int p1, input int p2);
        check_eq({tag, " p1"}, 32'(score_p1), 32'(p1));
        check_eq({tag, " p2"}, 32'(score_p2), 32'(p2));
    endtask

    initial begin
        // Reset with launch held; release reset while still held.
        btn_launch = 1'b1;
        reset = 1'b1;
        step(); step(); step();
        check_eq("reset state", 32'(state), MENU);
        check_scores("reset", 0, 0);
        check_eq("reset max", 32'(max_score), 5);
        check_eq("reset serve", 32'(serve_side), 0);
        check_eq("reset winner", 32'(winner), 0);
        check_eq("reset run", 32'(run), 0);
        reset = 1'b0;
        step(); step();
        check_eq("held launch no event", 32'(state), MENU);
        btn_launch = 1'b0;
        step();
        check_eq("release no event", 32'(state), MENU);
        press(0);
        check_eq("menu->set", 32'(state), SET);

        // Max-score saturation both ways, then simultaneous up+down.
        for (int i = 0; i < 12; i++) press(1);
        check_eq("max sat high", 32'(max_score), 15);
        for (int i = 0; i < 20; i++) press(2);
        check_eq("max sat low", 32'(max_score), 1);
        press(6);
        check_eq("up+down no change", 32'(max_score), 1);
        press(3);
        check_scores("hit in SET", 0, 0);
        press(1);
        check_eq("max=2", 32'(max_score), 2);

        // First point to p1.
        press(0);
        check_eq("set->start", 32'(state), START);
        check_eq("start ball_reset", 32'(ball_reset), 1);
        press(4);
        check_scores("hit in START", 0, 0);
        check_eq("hit in START state", 32'(state), START);
        press(0);
        check_eq("start->play", 32'(state), PLAY);
        check_eq("play run", 32'(run), 1);
        press(0);
        check_eq("launch ignored in PLAY", 32'(state), PLAY);
        press(4);
        check_eq("right hit -> end_point", 32'(state), END_POINT);
        check_scores("right hit", 1, 0);
        check_eq("right hit serve", 32'(serve_side), 1);
        check_eq("end_point run", 32'(run), 0);
        ticks(59);
        check_eq("hold 59 ticks", 32'(state), END_POINT);
        ticks(1);
        check_eq("hold 60 ticks", 32'(state), START);
        check_eq("back to start ball_reset", 32'(ball_reset), 1);
        check_eq("no winner yet", 32'(winner), 0);

        // Double hit: no score, serve unchanged.
        press(0);
        press(5);
        check_eq("double hit state", 32'(state), END_POINT);
        check_scores("double hit", 1, 0);
        check_eq("double hit serve", 32'(serve_side), 1);
        ticks(60);
        check_eq("double hit -> start", 32'(state), START);

        // p1 reaches max=2 and wins.
        press(0);
        press(4);
        check_scores("p1 second point", 2, 0);
        ticks(60);
        check_eq("p1 win state", 32'(state), END_GAME);
        check_eq("p1 winner", 32'(winner), 1);
        press(3);
        check_scores("hit in END_GAME", 2, 0);
        press(0);
        check_eq("end_game->menu", 32'(state), MENU);
        check_eq("winner cleared", 32'(winner), 0);
        check_scores("scores kept in MENU", 2, 0);

        // max=1, p2 wins on a left hit.
        press(0);
        check_scores("scores kept in SET", 2, 0);
        press(2);
        check_eq("max=1", 32'(max_score), 1);
        press(0);
        check_scores("cleared on start", 0, 0);
        press(0);
        press(3);
        check_scores("left hit", 0, 1);
        check_eq("left hit serve", 32'(serve_side), 0);
        ticks(60);
        check_eq("p2 win state", 32'(state), END_GAME);
        check_eq("p2 winner", 32'(winner), 2);
        press(0);
        check_eq("p2 game -> menu", 32'(state), MENU);
        check_eq("p2 winner cleared", 32'(winner), 0);
        check_scores("p2 scores kept", 0, 1);

        // Reset in the middle of an END_POINT hold.
        press(0);
        press(0);
        press(0);
        press(4);
        check_eq("pre-reset end_point", 32'(state), END_POINT);
        check_scores("pre-reset", 1, 0);
        ticks(30);
        reset = 1'b1;
        step();
        check_eq("mid-hold reset state", 32'(state), MENU);
        check_scores("mid-hold reset", 0, 0);
        check_eq("mid-hold reset max", 32'(max_score), 5);
        check_eq("mid-hold reset serve", 32'(serve_side), 0);
        reset = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
